// File: rtl/tone_decoder.sv
// Tone decoder: measures the half-period of a piezo square wave, classifies it
// against a 14-note table and locks onto a note after MATCH_N consistent
// half-periods. Silence is declared after TIMEOUT cycles without an edge.
module tone_decoder #(
  parameter int TOL     = 8,
  parameter int MATCH_N = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tone_in,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        note_on,
  output logic        note_off,
  output logic [12:0] period
);

  localparam logic [3:0]  KEY_NONE  = 4'd14;
  localparam logic [12:0] TIMEOUT_C = 13'(TIMEOUT);
  localparam logic [3:0]  MATCH_C   = 4'(MATCH_N);
  localparam logic [12:0] TOL_C     = 13'(TOL);

  localparam logic [12:0] NOM [0:13] = '{
    13'd1912, 13'd1703, 13'd1517, 13'd1432, 13'd1276, 13'd1137, 13'd1013,
    13'd956,  13'd852,  13'd759,  13'd716,  13'd638,  13'd569,  13'd507
  };

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  logic        sync1_q, sync2_q, hist_q;
  logic [12:0] cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic [3:0]  key_q, key_d;
  logic        key_valid_q, key_valid_d;
  logic        note_on_q, note_on_d;
  logic        note_off_q, note_off_d;
  logic [12:0] period_q, period_d;

  logic        edge_det;
  logic        cls_hit;
  logic [3:0]  cls_idx;
  logic [12:0] diff;
  logic [3:0]  acq_cand;
  logic [3:0]  acq_mcnt;

  assign edge_det = sync2_q ^ hist_q;

  // Classify the current interval; descending scan so the lowest index wins
  // if a wide tolerance makes neighbouring windows overlap.
  always_comb begin
    cls_hit = 1'b0;
    cls_idx = KEY_NONE;
    diff    = '0;
    for (int i = 13; i >= 0; i--) begin
      diff = (cnt_q >= NOM[i]) ? (cnt_q - NOM[i]) : (NOM[i] - cnt_q);
      if (diff <= TOL_C) begin
        cls_hit = 1'b1;
        cls_idx = 4'(i);
      end
    end
  end

  // Candidate/match-count update shared by ACQUIRE and the LOCKED fall-back.
  always_comb begin
    acq_cand = cand_q;
    acq_mcnt = 4'd0;
    if (cls_hit) begin
      if (cls_idx == cand_q) begin
        acq_mcnt = mcnt_q + 4'd1;
      end else begin
        acq_cand = cls_idx;
        acq_mcnt = 4'd1;
      end
    end
  end

  // Next-state logic: interval counter, FSM and registered outputs.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    mcnt_d      = mcnt_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    period_d    = period_q;
    note_on_d   = 1'b0;
    note_off_d  = 1'b0;
    cnt_d       = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + 13'd1;

    if (edge_det) begin
      cnt_d    = 13'd1;
      period_d = cnt_q;
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          mcnt_d  = 4'd0;
        end
        ACQUIRE: begin
          cand_d = acq_cand;
          mcnt_d = acq_mcnt;
          if (acq_mcnt == MATCH_C) begin
            state_d     = LOCKED;
            key_d       = acq_cand;
            key_valid_d = 1'b1;
            note_on_d   = 1'b1;
          end
        end
        LOCKED: begin
          if (!(cls_hit && cls_idx == key_q)) begin
            state_d     = ACQUIRE;
            key_d       = KEY_NONE;
            key_valid_d = 1'b0;
            cand_d      = acq_cand;
            mcnt_d      = acq_mcnt;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && cnt_q == TIMEOUT_C) begin
      state_d     = IDLE;
      key_d       = KEY_NONE;
      key_valid_d = 1'b0;
      mcnt_d      = 4'd0;
      note_off_d  = (state_q == LOCKED);
    end
  end

  // State registers, synchronizer and history flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      hist_q      <= 1'b0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      cand_q      <= KEY_NONE;
      mcnt_q      <= 4'd0;
      key_q       <= KEY_NONE;
      key_valid_q <= 1'b0;
      note_on_q   <= 1'b0;
      note_off_q  <= 1'b0;
      period_q    <= '0;
    end else begin
      sync1_q     <= tone_in;
      sync2_q     <= sync1_q;
      hist_q      <= sync2_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      mcnt_q      <= mcnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      note_on_q   <= note_on_d;
      note_off_q  <= note_off_d;
      period_q    <= period_d;
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign note_on   = note_on_q;
  assign note_off  = note_off_q;
  assign period    = period_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: drives square-wave edges at chosen gaps, queues the
// expected key/valid/period for each edge and compares once outputs settle.
module tb_tone_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tone_in = 1'b0;
  logic [3:0]  key;
  logic        key_valid;
  logic        note_on;
  logic        note_off;
  logic [12:0] period;

  tone_decoder #(.TOL(8), .MATCH_N(4), .TIMEOUT(4096)) dut (
    .clk       (clk),
    .reset     (reset),
    .tone_in   (tone_in),
    .key       (key),
    .key_valid (key_valid),
    .note_on   (note_on),
    .note_off  (note_off),
    .period    (period)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  key;
    logic        valid;
    logic        chk_p;
    logic [12:0] period;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int since    = 0;
  int on_cnt   = 0;
  int off_cnt  = 0;
  int both_cnt = 0;
  int on_base;
  int off_base;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (note_on)  on_cnt++;
    if (note_off) off_cnt++;
    if (note_on && note_off) both_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    since += n;
  endtask

  task automatic do_reset();
    tone_in = 1'b0;
    wait_cycles(4);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    check_val("rst_key", 32'(key), 32'd14);
    check_val("rst_valid", 32'(key_valid), 32'd0);
    check_val("rst_period", 32'(period), 32'd0);
    check_val("rst_note_on", 32'(note_on), 32'd0);
    check_val("rst_note_off", 32'(note_off), 32'd0);
    on_base  = on_cnt;
    off_base = off_cnt;
  endtask

  // Toggle tone_in 'gap' cycles after the previous toggle, then check.
  task automatic tone_edge(input string tag, input int gap, input logic [3:0] k,
                           input logic v, input logic cp);
    exp_t e;
    if (gap > since) wait_cycles(gap - since);
    tone_in = ~tone_in;
    since = 0;
    e.key = k; e.valid = v; e.chk_p = cp; e.period = 13'(gap);
    sb_q.push_back(e);
    wait_cycles(5);
    e = sb_q.pop_front();
    check_val({tag, "_key"}, 32'(key), 32'(e.key));
    check_val({tag, "_valid"}, 32'(key_valid), 32'(e.valid));
    if (e.chk_p) check_val({tag, "_period"}, 32'(period), 32'(e.period));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Lock onto 1912 after four matching intervals.
    do_reset(); since = 0;
    tone_edge("a1", 20, 4'd14, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tone_edge("a_acq", 1912, 4'd14, 1'b0, 1'b1);
    tone_edge("a_lock", 1912, 4'd0, 1'b1, 1'b1);
    tone_edge("a_hold", 1912, 4'd0, 1'b1, 1'b1);
    check_val("a_note_on_cnt", 32'(on_cnt - on_base), 32'd1);
    check_val("a_note_off_cnt", 32'(off_cnt - off_base), 32'd0);

    // Tolerance boundaries around 956: 948/964 match, 965 does not.
    do_reset(); since = 0;
    tone_edge("b1", 20, 4'd14, 1'b0, 1'b0);
    tone_edge("b_948", 948, 4'd14, 1'b0, 1'b1);
    tone_edge("b_964", 964, 4'd14, 1'b0, 1'b1);
    tone_edge("b_956", 956, 4'd14, 1'b0, 1'b1);
    tone_edge("b_lock", 948, 4'd7, 1'b1, 1'b1);
    tone_edge("b_965", 965, 4'd14, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tone_edge("b_reacq", 964, 4'd14, 1'b0, 1'b1);
    tone_edge("b_relock", 964, 4'd7, 1'b1, 1'b1);
    check_val("b_note_on_cnt", 32'(on_cnt - on_base), 32'd2);

    // Lock on 1137, switch to 507, then an edge exactly at the timeout.
    do_reset(); since = 0;
    tone_edge("c1", 20, 4'd14, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tone_edge("c_acq", 1137, 4'd14, 1'b0, 1'b1);
    tone_edge("c_lock", 1137, 4'd5, 1'b1, 1'b1);
    tone_edge("c_hold", 1137, 4'd5, 1'b1, 1'b1);
    tone_edge("c_drop", 507, 4'd14, 1'b0, 1'b1);
    tone_edge("c_acq2", 507, 4'd14, 1'b0, 1'b1);
    tone_edge("c_acq3", 507, 4'd14, 1'b0, 1'b1);
    tone_edge("c_lock13", 507, 4'd13, 1'b1, 1'b1);
    check_val("c_note_on_cnt", 32'(on_cnt - on_base), 32'd2);
    tone_edge("c_hold13", 507, 4'd13, 1'b1, 1'b1);
    tone_edge("c_edge_at_to", 4096, 4'd14, 1'b0, 1'b1);
    check_val("c_no_note_off", 32'(off_cnt - off_base), 32'd0);
    wait_cycles(4100 - since);
    check_val("c_acq_to_key", 32'(key), 32'd14);
    check_val("c_acq_to_valid", 32'(key_valid), 32'd0);
    check_val("c_acq_to_no_off", 32'(off_cnt - off_base), 32'd0);

    // Lock on 852 then silence: one note_off after TIMEOUT.
    do_reset(); since = 0;
    tone_edge("d1", 20, 4'd14, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tone_edge("d_acq", 852, 4'd14, 1'b0, 1'b1);
    tone_edge("d_lock", 852, 4'd8, 1'b1, 1'b1);
    tone_edge("d_hold", 852, 4'd8, 1'b1, 1'b1);
    wait_cycles(4090 - since);
    check_val("d_pre_to_valid", 32'(key_valid), 32'd1);
    check_val("d_pre_to_off", 32'(off_cnt - off_base), 32'd0);
    wait_cycles(4105 - since);
    check_val("d_to_key", 32'(key), 32'd14);
    check_val("d_to_valid", 32'(key_valid), 32'd0);
    check_val("d_to_off", 32'(off_cnt - off_base), 32'd1);
    check_val("d_to_period", 32'(period), 32'd852);

    // Reset while locked, then the same tone needs 1 + MATCH_N edges.
    do_reset(); since = 0;
    tone_edge("e1", 20, 4'd14, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tone_edge("e_acq", 852, 4'd14, 1'b0, 1'b1);
    tone_edge("e_lock", 852, 4'd8, 1'b1, 1'b1);
    tone_edge("e_hold", 852, 4'd8, 1'b1, 1'b1);
    wait_cycles(95);
    do_reset();
    tone_edge("e_idle_edge", 852, 4'd14, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tone_edge("e_reacq", 852, 4'd14, 1'b0, 1'b1);
    tone_edge("e_relock", 852, 4'd8, 1'b1, 1'b1);
    check_val("e_note_on_cnt", 32'(on_cnt - on_base), 32'd1);

    check_val("on_off_overlap", 32'(both_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
